// File: rtl/jtcps1_scroll_sched_if.sv
// Shared bus between the three scroll engines and the single SDRAM VRAM read channel.
// The master modport is the arbiter side; the slave modport is the layer/SDRAM side.
interface jtcps1_scroll_sched_if;
  logic [2:0]  req_cs;     // per-layer request, held across multi-word accesses
  logic [68:0] req_addr;   // layer i word address at [23i+22:23i]
  logic [2:0]  req_ok;     // per-layer data-valid
  logic [15:0] req_data;   // VRAM data broadcast to every layer
  logic [22:0] vram_addr;
  logic        vram_cs;
  logic [15:0] vram_data;
  logic        vram_ok;

  modport master (
    input  req_cs, req_addr, vram_data, vram_ok,
    output req_ok, req_data, vram_addr, vram_cs
  );

  modport slave (
    output req_cs, req_addr, vram_data, vram_ok,
    input  req_ok, req_data, vram_addr, vram_cs
  );
endinterface

// File: rtl/jtcps1_scroll_sched.sv
// Per-line scheduler and VRAM arbiter for the three CPS1 scroll layer engines.
// Launches every enabled layer at each line_start, shares one VRAM read port with a
// locked round-robin arbiter and flags when all enabled layers have finished the line.
// Optional watchdog: define JTCPS1_SCHED_WDOG_EN to build the RUN timeout counter.
module jtcps1_scroll_sched #(
  parameter int unsigned START_LEN = 2,
  parameter int unsigned WDOG_MAX  = 1500
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         line_start,
  input  logic [2:0]                   layer_en,
  output logic [2:0]                   start,
  input  logic [2:0]                   done,
  jtcps1_scroll_sched_if.master        bus,
  output logic                         line_ok,
  output logic                         overrun,
  output logic                         timeout
);

  if (START_LEN == 0 || WDOG_MAX == 0) begin : g_param_check
    $error("START_LEN and WDOG_MAX must be nonzero");
  end

  localparam int unsigned CntW = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e          st_q, st_d;
  logic [2:0]      en_q, en_d;
  logic [2:0]      start_q, start_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mask_q, mask_d;     // masks done on the first RUN cycle
  logic            overrun_q, overrun_d;

`ifdef JTCPS1_SCHED_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_MAX + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;
`endif

  // Sequencer next state: line_start always wins and restarts the START phase
  always_comb begin
    st_d      = st_q;
    en_d      = en_q;
    start_d   = start_q;
    cnt_d     = cnt_q;
    mask_d    = 1'b0;
    overrun_d = 1'b0;
`ifdef JTCPS1_SCHED_WDOG_EN
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (st_q == StStart || st_q == StRun) wdog_d = wdog_q + 1'b1;
`endif
    if (line_start) begin
      overrun_d = (st_q == StStart) || (st_q == StRun);
      st_d      = StStart;
      en_d      = layer_en;
      start_d   = layer_en;
      cnt_d     = CntW'(START_LEN - 1);
`ifdef JTCPS1_SCHED_WDOG_EN
      wdog_d    = '0;
`endif
    end else begin
      case (st_q)
        StStart: begin
          if (cnt_q == '0) begin
            start_d = 3'b000;
            mask_d  = 1'b1;
            st_d    = StRun;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StRun: begin
          if (!mask_q && ((done | ~en_q) == 3'b111)) st_d = StDone;
`ifdef JTCPS1_SCHED_WDOG_EN
          else if (wdog_q == WdogW'(WDOG_MAX - 1)) begin
            st_d      = StDone;
            timeout_d = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= StIdle;
      en_q      <= 3'b000;
      start_q   <= 3'b000;
      cnt_q     <= '0;
      mask_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      en_q      <= en_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef JTCPS1_SCHED_WDOG_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign start   = start_q;
  assign line_ok = (st_q == StDone);
  assign overrun = overrun_q;

  // ---------------------------------------------------------------------------------------
  // Arbiter. Entry 3 is padding so a 2-bit index never leaves the array.
  logic [3:0][22:0] addr_a;
  logic [3:0]       cs_a;
  assign addr_a = {23'd0, bus.req_addr};
  assign cs_a   = {1'b0, bus.req_cs};

  logic [1:0]  gnt_q, gnt_d, ptr_q, ptr_d, idx, pick;
  logic        gv_q, gv_d, pick_v;
  logic        cs_q, cs_d;
  logic [22:0] addr_q, addr_d;
  logic [2:0]  ok;

  // Round-robin pick: first requester at or after the pointer
  always_comb begin
    pick   = 2'd0;
    pick_v = 1'b0;
    idx    = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!pick_v && cs_a[idx]) begin
        pick   = idx;
        pick_v = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  // Grant lock/release; a release always costs one idle cycle on vram_cs
  always_comb begin
    gnt_d  = gnt_q;
    gv_d   = gv_q;
    ptr_d  = ptr_q;
    cs_d   = cs_q;
    addr_d = addr_q;
    if (gv_q) begin
      if (cs_a[gnt_q]) begin
        cs_d   = 1'b1;
        addr_d = addr_a[gnt_q];
      end else begin
        gv_d  = 1'b0;
        cs_d  = 1'b0;
        ptr_d = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
      end
    end else if (pick_v) begin
      gv_d   = 1'b1;
      gnt_d  = pick;
      cs_d   = 1'b1;
      addr_d = addr_a[pick];
    end
  end

  // Arbiter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= 2'd0;
      gv_q   <= 1'b0;
      ptr_q  <= 2'd0;
      cs_q   <= 1'b0;
      addr_q <= 23'd0;
    end else begin
      gnt_q  <= gnt_d;
      gv_q   <= gv_d;
      ptr_q  <= ptr_d;
      cs_q   <= cs_d;
      addr_q <= addr_d;
    end
  end

  // Data-valid only for the owner, and only once its current address is registered
  always_comb begin
    ok = 3'b000;
    for (int k = 0; k < 3; k++) begin
      ok[k] = bus.vram_ok & cs_q & gv_q & (gnt_q == 2'(k)) & (addr_q == addr_a[k]);
    end
  end

  assign bus.req_ok    = ok;
  assign bus.req_data  = bus.vram_data;
  assign bus.vram_cs   = cs_q;
  assign bus.vram_addr = addr_q;

endmodule

// File: tb/tb_jtcps1_scroll_sched.sv
// Directed self-checking bench for jtcps1_scroll_sched.
module tb_jtcps1_scroll_sched;
  localparam int unsigned WdogMax = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       line_start = 1'b0;
  logic [2:0] layer_en = 3'b000;
  logic [2:0] start;
  logic [2:0] done = 3'b000;
  logic       line_ok, overrun, timeout;
  int         checks = 0;
  int         errors = 0;

  jtcps1_scroll_sched_if bus ();

  jtcps1_scroll_sched #(.START_LEN(2), .WDOG_MAX(WdogMax)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_start(line_start),
    .layer_en  (layer_en),
    .start     (start),
    .done      (done),
    .bus       (bus),
    .line_ok   (line_ok),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_cs = 3'b000; bus.req_addr = '0; bus.vram_data = 16'h0; bus.vram_ok = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    checks++; if (start !== 3'b000) begin errors++; $display("FAIL reset_start got %b want 000", start); end
    checks++; if (line_ok !== 1'b0) begin errors++; $display("FAIL reset_line_ok got %b want 0", line_ok); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    checks++; if (bus.vram_cs !== 1'b0) begin errors++; $display("FAIL reset_vram_cs got %b want 0", bus.vram_cs); end
    checks++; if (bus.vram_addr !== 23'd0) begin errors++; $display("FAIL reset_vram_addr got %h want 0", bus.vram_addr); end
    checks++; if (bus.req_ok !== 3'b000) begin errors++; $display("FAIL reset_req_ok got %b want 000", bus.req_ok); end
    rst_n = 1'b1;
    tick();
  endtask

  // All layers enabled; done on layers 0, 2, 1 at cycles 100, 120, 140
  task automatic test_line_all();
    layer_en = 3'b111; done = 3'b000; line_start = 1'b1;
    for (int c = 1; c <= 141; c++) begin
      tick(); line_start = 1'b0;
      if (c <= 2) begin
        checks++; if (start !== 3'b111) begin errors++; $display("FAIL all_start c=%0d got %b want 111", c, start); end
      end
      if (c == 1) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL all_overrun got %b want 0", overrun); end
      end
      if (c == 3) begin
        checks++; if (start !== 3'b000) begin errors++; $display("FAIL all_start_end got %b want 000", start); end
      end
      if (c == 140) begin
        checks++; if (line_ok !== 1'b0) begin errors++; $display("FAIL all_line_ok_early got %b want 0", line_ok); end
      end
      if (c == 141) begin
        checks++; if (line_ok !== 1'b1) begin errors++; $display("FAIL all_line_ok got %b want 1", line_ok); end
      end
      if (c == 100) done[0] = 1'b1;
      if (c == 120) done[2] = 1'b1;
      if (c == 140) done[1] = 1'b1;
    end
  endtask

  // Only layer 1 enabled; stale done from the previous line must be ignored
  task automatic test_stale_done();
    layer_en = 3'b010; done = 3'b111; line_start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick(); line_start = 1'b0;
      if (c <= 2) begin
        checks++; if (start !== 3'b010) begin errors++; $display("FAIL one_start c=%0d got %b want 010", c, start); end
      end
      if (c == 3) begin
        checks++; if (start !== 3'b000) begin errors++; $display("FAIL one_start_end got %b want 000", start); end
      end
      if (c == 1 || c == 4 || c == 10) begin
        checks++; if (line_ok !== 1'b0) begin errors++; $display("FAIL one_line_ok_low c=%0d got %b want 0", c, line_ok); end
      end
      if (c == 11) begin
        checks++; if (line_ok !== 1'b1) begin errors++; $display("FAIL one_line_ok got %b want 1", line_ok); end
      end
      if (c == 4) done = 3'b101;
      if (c == 10) done = 3'b111;
    end
  endtask

  // line_start in RUN with only done[0] high
  task automatic test_overrun();
    layer_en = 3'b111; done = 3'b001; line_start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick(); line_start = 1'b0;
      if (c == 10 || c == 12) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_low c=%0d got %b want 0", c, overrun); end
      end
      if (c == 11) begin
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", overrun); end
      end
      if (c == 11 || c == 12) begin
        checks++; if (start !== 3'b111) begin errors++; $display("FAIL ovr_start c=%0d got %b want 111", c, start); end
      end
      if (c == 13) begin
        checks++; if (start !== 3'b000) begin errors++; $display("FAIL ovr_start_end got %b want 000", start); end
      end
      if (c == 20) begin
        checks++; if (line_ok !== 1'b0) begin errors++; $display("FAIL ovr_line_ok got %b want 0", line_ok); end
      end
      if (c == 25) begin
        checks++; if (line_ok !== 1'b1) begin errors++; $display("FAIL ovr_recover got %b want 1", line_ok); end
      end
      if (c == 10) line_start = 1'b1;
      if (c == 21) done = 3'b111;
    end
  endtask

  // Locked round-robin with one-cycle handover gap; owner 3 means vram_cs low
  task automatic test_arb_rr();
    logic [2:0] req_tab [19] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b110,
                                 3'b110, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                 3'b000, 3'b011, 3'b010, 3'b011, 3'b000};
    int own_tab [19] = '{0, 0, 0, 0, 3, 1, 1, 1, 1, 3, 2, 2, 2, 2, 3, 0, 3, 1, 3};
    logic [22:0] want;
    bus.req_addr = {23'h000300, 23'h000200, 23'h000100};
    for (int k = 0; k < 19; k++) begin
      bus.req_cs = req_tab[k];
      tick();
      checks++;
      if (bus.vram_cs !== (own_tab[k] != 3)) begin
        errors++; $display("FAIL arb_cs k=%0d got %b want %b", k, bus.vram_cs, own_tab[k] != 3);
      end
      if (own_tab[k] != 3) begin
        want = 23'h000100 * 23'(own_tab[k] + 1);
        checks++;
        if (bus.vram_addr !== want) begin
          errors++; $display("FAIL arb_addr k=%0d got %h want %h", k, bus.vram_addr, want);
        end
      end
    end
  endtask

  // Owner changes address mid-lock; ok must drop for exactly that cycle
  task automatic test_addr_change();
    bus.req_addr = {23'h000000, 23'h001001, 23'h001000};
    bus.vram_ok = 1'b1; bus.vram_data = 16'hBEEF; bus.req_cs = 3'b001;
    tick();
    checks++; if (bus.req_ok !== 3'b001) begin errors++; $display("FAIL chg_ok_before got %b want 001", bus.req_ok); end
    checks++; if (bus.req_data !== 16'hBEEF) begin errors++; $display("FAIL chg_data got %h want beef", bus.req_data); end
    bus.req_addr[22:0] = 23'h001001;
    #1;
    checks++; if (bus.req_ok !== 3'b000) begin errors++; $display("FAIL chg_ok_block got %b want 000", bus.req_ok); end
    tick();
    checks++; if (bus.vram_addr !== 23'h001001) begin errors++; $display("FAIL chg_addr got %h want 001001", bus.vram_addr); end
    checks++; if (bus.req_ok !== 3'b001) begin errors++; $display("FAIL chg_ok_after got %b want 001", bus.req_ok); end
  endtask

  // Asynchronous reset in the middle of a locked transfer
  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.vram_cs !== 1'b0) begin errors++; $display("FAIL arst_cs got %b want 0", bus.vram_cs); end
    checks++; if (bus.req_ok !== 3'b000) begin errors++; $display("FAIL arst_ok got %b want 000", bus.req_ok); end
    tick();
    rst_n = 1'b1; bus.req_cs = 3'b000;
    tick();
    checks++; if (bus.req_ok !== 3'b000) begin errors++; $display("FAIL arst_ok_idle got %b want 000", bus.req_ok); end
    bus.req_cs = 3'b001;
    tick();
    checks++; if (bus.vram_cs !== 1'b1) begin errors++; $display("FAIL arst_regrant got %b want 1", bus.vram_cs); end
    checks++; if (bus.req_ok !== 3'b001) begin errors++; $display("FAIL arst_ok_regrant got %b want 001", bus.req_ok); end
    bus.req_cs = 3'b000;
    tick();
  endtask

`ifdef JTCPS1_SCHED_WDOG_EN
  // done never rises; RUN is forced to DONE 50 cycles after START entry
  task automatic test_watchdog();
    layer_en = 3'b111; done = 3'b000; line_start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      tick(); line_start = 1'b0;
      if (c == 50) begin
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wdog_early got %b want 0", timeout); end
        checks++; if (line_ok !== 1'b0) begin errors++; $display("FAIL wdog_ok_early got %b want 0", line_ok); end
      end
      if (c >= 51) begin
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wdog_timeout c=%0d got %b want 1", c, timeout); end
        checks++; if (line_ok !== 1'b1) begin errors++; $display("FAIL wdog_line_ok c=%0d got %b want 1", c, line_ok); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line_all();
    test_stale_done();
    test_overrun();
    test_arb_rr();
    test_addr_change();
    test_async_reset();
`ifdef JTCPS1_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
